// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, debounce filter, press/release
// pulses and optional auto-repeat for each button channel.
module button_conditioner #(
  parameter int unsigned              NUM_BUTTONS         = 6,
  parameter int unsigned              DEBOUNCE_CYCLES     = 1250000,
  parameter int unsigned              REPEAT_DELAY_CYCLES = 62500000,
  parameter int unsigned              REPEAT_RATE_CYCLES  = 12500000,
  parameter logic [NUM_BUTTONS-1:0]   REPEAT_MASK         = 6'b011000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_pulse,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  localparam int unsigned DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DCW-1:0] DEB_TERM   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RDLY_TERM  = RCW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCW-1:0] RRATE_TERM = RCW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;

  // Metastability guard on the asynchronous button inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
    logic [DCW-1:0] r_dcnt;
    logic           r_stable;
    logic           r_pulse;
    logic           r_release;
    logic           w_accept;
    logic           w_press;
    logic           w_rel;
    logic           w_rep;

    // Level change is accepted on the Nth consecutive differing synced sample
    assign w_accept = (r_sync2[gi] != r_stable) && (r_dcnt == DEB_TERM);
    assign w_press  = w_accept &  r_sync2[gi];
    assign w_rel    = w_accept & ~r_sync2[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_dcnt   <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[gi] == r_stable) begin
        r_dcnt   <= '0;
      end else if (r_dcnt == DEB_TERM) begin
        r_stable <= r_sync2[gi];
        r_dcnt   <= '0;
      end else begin
        r_dcnt   <= r_dcnt + DCW'(1);
      end
    end

    if (REPEAT_MASK[gi]) begin : g_rep
      rep_state_e     r_state;
      rep_state_e     w_state_nxt;
      logic [RCW-1:0] r_rcnt;
      logic [RCW-1:0] w_rcnt_nxt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_rcnt  <= w_rcnt_nxt;
        end
      end

      // Release wins over a coinciding terminal count so no pulse follows it
      always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rep       = 1'b0;
        if (w_rel) begin
          w_state_nxt = ST_IDLE;
          w_rcnt_nxt  = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_press) begin
                w_state_nxt = ST_DELAY;
                w_rcnt_nxt  = '0;
              end
            end
            ST_DELAY: begin
              if (r_rcnt == RDLY_TERM) begin
                w_rep       = 1'b1;
                w_rcnt_nxt  = '0;
                w_state_nxt = ST_REPEAT;
              end else begin
                w_rcnt_nxt  = r_rcnt + RCW'(1);
              end
            end
            ST_REPEAT: begin
              if (r_rcnt == RRATE_TERM) begin
                w_rep       = 1'b1;
                w_rcnt_nxt  = '0;
              end else begin
                w_rcnt_nxt  = r_rcnt + RCW'(1);
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_rcnt_nxt  = '0;
            end
          endcase
        end
      end
    end else begin : g_norep
      assign w_rep = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pulse   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_pulse   <= w_press | w_rep;
        r_release <= w_rel;
      end
    end

    assign btn_level[gi]   = r_stable;
    assign btn_pulse[gi]   = r_pulse;
    assign btn_release[gi] = r_release;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a sliding-window reference model
// predicts every pulse/release event, a monitor matches them as they appear.
`timescale 1ns/1ps
module tb_button_conditioner;
  localparam int NB = 6;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  typedef struct {
    int          edge_no;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pulse;
    logic [NB-1:0] rel;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_release;

  button_conditioner #(
    .NUM_BUTTONS        (NB),
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR),
    .REPEAT_MASK        (6'b011000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release)
  );

  always #4 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];

  // Reference model state: raw sample history (bit 0 = newest), level, press edge
  logic [NB-1:0] mask_v = 6'b011000;
  logic [DB+1:0] m_hist [NB];
  logic [NB-1:0] m_lvl;
  int            m_press [NB];

  task automatic model_reset();
    m_lvl = '0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c]  = '0;
      m_press[c] = 0;
    end
  endtask

  // Drive raw now (at a negedge) and predict the outcome of the next edge
  task automatic apply(input logic [NB-1:0] raw);
    ev_t ev;
    int k;
    logic [NB-1:0] p;
    logic [NB-1:0] r;
    bit all_diff;
    btn_raw = raw;
    k = edge_cnt + 1;
    p = '0;
    r = '0;
    for (int c = 0; c < NB; c++) begin
      m_hist[c] = {m_hist[c][DB:0], raw[c]};
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++)
        if (m_hist[c][j] == m_lvl[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c]) begin
          p[c] = 1'b1;
          m_press[c] = k;
        end else begin
          r[c] = 1'b1;
        end
      end else if (m_lvl[c] && mask_v[c] && (k - m_press[c]) >= RD &&
                   ((k - m_press[c] - RD) % RR) == 0) begin
        p[c] = 1'b1;
      end
    end
    if ((p | r) != '0) begin
      ev.edge_no = k;
      ev.lvl     = m_lvl;
      ev.pulse   = p;
      ev.rel     = r;
      exp_q.push_back(ev);
    end
  endtask

  task automatic step(input logic [NB-1:0] raw);
    @(negedge clk);
    apply(raw);
  endtask

  task automatic hold(input logic [NB-1:0] raw, input int n);
    repeat (n) step(raw);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (btn_level != '0 || btn_pulse != '0 || btn_release != '0) begin
      n_fail++;
      $display("FAIL %s: got level=%b pulse=%b release=%b, want all zero",
               name, btn_level, btn_pulse, btn_release);
    end
  endtask

  // Reset asserted on a negedge for n clock edges; raw inputs keep their value
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_immediate");
    repeat (n - 1) @(negedge clk);
    check_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(btn_raw);
  endtask

  // Monitor: match each DUT event against the oldest predicted event
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
        ev = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: got nothing at edge %0d, want pulse=%b rel=%b lvl=%b",
                 ev.edge_no, ev.pulse, ev.rel, ev.lvl);
      end
      if ((btn_pulse | btn_release) != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got edge %0d pulse=%b rel=%b lvl=%b, want no event",
                   edge_cnt, btn_pulse, btn_release, btn_level);
        end else begin
          ev = exp_q.pop_front();
          if (ev.edge_no != edge_cnt || ev.pulse != btn_pulse ||
              ev.rel != btn_release || ev.lvl != btn_level) begin
            n_fail++;
            $display("FAIL event_match: got edge %0d pulse=%b rel=%b lvl=%b, want edge %0d pulse=%b rel=%b lvl=%b",
                     edge_cnt, btn_pulse, btn_release, btn_level,
                     ev.edge_no, ev.pulse, ev.rel, ev.lvl);
          end
        end
      end
    end
  end

  initial begin
    logic [NB-1:0] cur;
    int hold_left [NB];
    ev_t ev;

    reset   = 1'b0;
    btn_raw = '0;
    model_reset();
    #2 reset = 1'b1;
    #1 check_zero("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_before_release");
    reset = 1'b0;
    apply('0);
    hold('0, 3);

    // Clean press and release on channel 0
    hold(6'b000001, 20);
    hold('0, 12);

    // Bounce: short runs of ones are rejected, then a steady hold
    step(6'b000010); step(6'b000000); step(6'b000010);
    step(6'b000010); step(6'b000000); step(6'b000010);
    hold(6'b000010, 12);
    hold('0, 12);

    // Auto-repeat on channel 3
    hold(6'b001000, 36);
    hold('0, 12);

    // Non-repeating channel 5 held long
    hold(6'b100000, 44);
    hold('0, 12);

    // Simultaneous presses on channels 0 and 4
    hold(6'b010001, 9);
    hold('0, 12);

    // Reset while channel 4 is repeating; button still held afterwards
    hold(6'b010000, 25);
    do_reset(3);
    hold(6'b010000, 24);
    hold('0, 12);

    // Random holds and bounces on all channels
    cur = '0;
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 40));
        end else begin
          hold_left[c]--;
        end
      end
      step(cur);
      if (n == 1500) do_reset(2);
    end

    hold('0, 20);
    @(negedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL leftover_event: got nothing, want edge %0d pulse=%b rel=%b",
               ev.edge_no, ev.pulse, ev.rel);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the six raw push-button inputs before they reach the traffic-light top level: change-mode, config, change-light, increase-time, decrease-time and confirm.
- Per button, in the 125 MHz clk domain: 2-flop synchronizer, debounce filter, then a clean debounced level plus a single-cycle press pulse.
- Increase/decrease buttons get optional auto-repeat pulses while held, so time values can be stepped quickly in config mode.
- The top level consumes btn_pulse in place of raw button edges.

Parameters:
- NUM_BUTTONS, 6, number of independent button channels.
- DEBOUNCE_CYCLES, 1250000, consecutive stable synced cycles required to accept a level change (10 ms at 125 MHz); legal range >= 2.
- REPEAT_DELAY_CYCLES, 62500000, cycles from the press pulse to the first repeat pulse (0.5 s).
- REPEAT_RATE_CYCLES, 12500000, cycles between subsequent repeat pulses (0.1 s); legal range >= 2.
- REPEAT_MASK, 6'b011000, bit i=1 enables auto-repeat on channel i (bits 3,4 = increase, decrease).

Ports:
- clk  input  1  125 MHz system clock.
- reset  input  1  asynchronous, active-high.
- btn_raw  input  NUM_BUTTONS  raw, asynchronous, bouncing button inputs (1 = pressed).
- btn_level  output  NUM_BUTTONS  debounced button level.
- btn_pulse  output  NUM_BUTTONS  one-cycle pulse on each accepted press and on each auto-repeat.
- btn_release  output  NUM_BUTTONS  one-cycle pulse on each accepted release.

Behaviour:
- Reset: reset asynchronous, active-high.
  - Clears all sync flops, stable levels, debounce counters and repeat FSMs.
  - btn_level, btn_pulse and btn_release are 0 while reset is high and on the first cycle after release.
- Synchronizer:
  - sync1 <= btn_raw; sync2 <= sync1; both are per-bit, reset to 0.
  - Only sync2 is used downstream.
- Debounce, per channel:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)).
  - Each edge with sync2 == stable: cnt <= 0.
  - Each edge with sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Each edge with sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - Latency: raw input held constant from its first sampling edge sees btn_level change after exactly DEBOUNCE_CYCLES+2 rising edges (that edge included).
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles produces no level change and no pulse.
- btn_level = stable, registered.
- btn_pulse[i] is registered and asserts in the same cycle btn_level[i] first reads 1 (0->1 transition), high for exactly one cycle.
- btn_release[i] is registered and asserts in the same cycle btn_level[i] first reads 0 (1->0 transition), for one cycle.
- Auto-repeat FSM, per channel with REPEAT_MASK[i]=1:
  - States IDLE, DELAY, REPEAT; one shared per-channel counter.
  - IDLE -> DELAY on the accepted press (coincides with the press pulse); counter cleared.
  - DELAY: counter increments each cycle. When it reaches REPEAT_DELAY_CYCLES-1: one repeat pulse, counter cleared, go to REPEAT.
  - REPEAT: when the counter reaches REPEAT_RATE_CYCLES-1: one repeat pulse, counter cleared, stay in REPEAT.
  - Any state -> IDLE on an accepted release, same edge. No pulse is issued on or after the release edge, even if a repeat terminal count coincides.
  - First repeat pulse is REPEAT_DELAY_CYCLES cycles after the press pulse; subsequent spacing is REPEAT_RATE_CYCLES.
- Channels with REPEAT_MASK[i]=0 stay in IDLE; a held button yields exactly one pulse.
- Channels are fully independent; simultaneous presses on multiple channels produce simultaneous pulses. No priority or encoding is applied.
- Reset mid-operation:
  - All state is cleared immediately and any pulse in progress is aborted.
  - A button still held after reset deasserts is debounced as a new press: pulse after DEBOUNCE_CYCLES+2 edges.
- Counters saturate by construction (clear on terminal count); no wrap-around glitches.
- No combinational path from btn_raw to any output.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, REPEAT_MASK=6'b011000.
- Clean press: raise btn_raw[0] at a fixed point, hold 20 cycles -> btn_level[0] rises on the 6th edge after first sampling; btn_pulse[0] is high exactly that one cycle; no further pulses; release gives btn_release[0] 6 edges later.
- Bounce rejection: btn_raw[1] toggles 1,0,1,1,0,1 on successive cycles (max run of 2 ones), then holds 1 -> no output until 4 consecutive synced 1s; exactly one btn_pulse[1].
- Auto-repeat: hold btn_raw[3] for 30 cycles after acceptance -> btn_pulse[3] at press cycle t, then t+10, t+13, t+16, t+19, ...; stops on the release-accept edge; btn_release[3] pulses once.
- Repeat on a non-masked channel: hold btn_raw[5] 40 cycles -> exactly one btn_pulse[5].
- Simultaneous: raise btn_raw[0] and btn_raw[4] on the same edge -> btn_pulse[0] and btn_pulse[4] assert in the same cycle.
- Reset mid-hold: btn_raw[4] held and in REPEAT, assert reset for 3 cycles -> all outputs 0 immediately. After deassert, btn_pulse[4] asserts on the 6th edge, then repeat pulses 10 cycles later.
